// File: rtl/imm_pkg.sv
// Shared opcode map and immediate format codes
// for the immediate decode stage.
package imm_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_OP_32  = 7'b0111011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Nine codes, so the field is 4 bits wide.
  typedef enum logic [3:0] {
    FMT_NONE = 4'd0,
    FMT_I    = 4'd1,
    FMT_S    = 4'd2,
    FMT_B    = 4'd3,
    FMT_U    = 4'd4,
    FMT_J    = 4'd5,
    FMT_R    = 4'd6,
    FMT_SH   = 4'd7,
    FMT_CSR  = 4'd8
  } fmt_e;

endpackage

// File: rtl/imm_if.sv
// Valid/ready bus between fetch, the immediate
// decode stage and execute.
interface imm_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
);
  import imm_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  fmt_e             out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt,
    input  out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt,
    output out_illegal, out_tag
  );

endinterface

// File: rtl/imm_decode_stage_extract.sv
// Combinational immediate extraction for all
// RV32I/RV64I formats.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0] op;
  logic [2:0] f3;
  logic       is_sh;
  logic       sh_ok;
  logic [5:0] shamt;

  function automatic logic [XLEN-1:0] sx(
    input logic [31:0] v
  );
    return XLEN'($signed(v));
  endfunction

  assign op    = instr[6:0];
  assign f3    = instr[14:12];
  assign is_sh = (f3 == 3'b001) || (f3 == 3'b101);
  assign shamt = RV64 ? instr[25:20]
                      : {1'b0, instr[24:20]};

  // Upper funct bits must select SLLI/SRLI/SRAI;
  // on RV32 bit 25 belongs to funct7.
  always_comb begin
    sh_ok = 1'b0;
    if (RV64)
      sh_ok = (instr[31:26] == 6'b000000) ||
              (f3 == 3'b101 &&
               instr[31:26] == 6'b010000);
    else
      sh_ok = (instr[31:25] == 7'b0000000) ||
              (f3 == 3'b101 &&
               instr[31:25] == 7'b0100000);
  end

  // Opcode decode; unmatched encodings are illegal.
  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    unique case (1'b1)
      (op == OP_IMM) && is_sh: begin
        if (sh_ok) begin
          fmt = FMT_SH;
          imm = XLEN'(shamt);
        end else begin
          illegal = 1'b1;
        end
      end
      (op == OP_IMM) && !is_sh,
      op == OP_LOAD,
      op == OP_JALR,
      op == OP_FENCE,
      (op == OP_SYSTEM) && (f3 == 3'b000),
      RV64 && (op == OP_IMM_32): begin
        fmt = FMT_I;
        imm = sx({{20{instr[31]}}, instr[31:20]});
      end
      op == OP_STORE: begin
        fmt = FMT_S;
        imm = sx({{20{instr[31]}},
                  instr[31:25], instr[11:7]});
      end
      op == OP_BRANCH: begin
        fmt = FMT_B;
        imm = sx({{20{instr[31]}}, instr[7],
                  instr[30:25], instr[11:8], 1'b0});
      end
      op == OP_LUI,
      op == OP_AUIPC: begin
        fmt = FMT_U;
        imm = sx({instr[31:12], 12'b0});
      end
      op == OP_JAL: begin
        fmt = FMT_J;
        imm = sx({{12{instr[31]}}, instr[19:12],
                  instr[20], instr[30:21], 1'b0});
      end
      op == OP_OP,
      RV64 && (op == OP_OP_32): begin
        fmt = FMT_R;
      end
      (op == OP_SYSTEM) && (f3 != 3'b000): begin
        fmt = FMT_CSR;
        imm = XLEN'(instr[19:15]);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Pipelined immediate decode: extractor, output
// register and one skid entry behind it.
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input logic  clk,
  input logic  rst_n,
  input logic  flush,
  imm_if.slave bus
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $fatal(1, "imm_decode_stage: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0]  dec_imm;
  fmt_e             dec_fmt;
  logic             dec_ill;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d;
  fmt_e             out_fmt_q, out_fmt_d;
  logic             out_ill_q, out_ill_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  fmt_e             skid_fmt_q, skid_fmt_d;
  logic             skid_ill_q, skid_ill_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

  logic acc;
  logic pop;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr   (bus.in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_ill)
  );

  assign acc = bus.in_valid && !skid_valid_q;
  assign pop = out_valid_q && bus.out_ready;

  // Output refills from skid first, then input;
  // a stalled output diverts input into the skid.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_fmt_d    = out_fmt_q;
    out_ill_d    = out_ill_q;
    out_tag_d    = out_tag_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    skid_ill_d   = skid_ill_q;
    skid_tag_d   = skid_tag_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || pop) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_fmt_d    = skid_fmt_q;
        out_ill_d    = skid_ill_q;
        out_tag_d    = skid_tag_q;
        skid_valid_d = 1'b0;
      end else if (acc) begin
        out_valid_d = 1'b1;
        out_imm_d   = dec_imm;
        out_fmt_d   = dec_fmt;
        out_ill_d   = dec_ill;
        out_tag_d   = bus.in_tag;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (acc) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_fmt_d   = dec_fmt;
      skid_ill_d   = dec_ill;
      skid_tag_d   = bus.in_tag;
    end
  end

  // State registers with async clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_fmt_q    <= FMT_NONE;
      out_ill_q    <= 1'b0;
      out_tag_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= FMT_NONE;
      skid_ill_q   <= 1'b0;
      skid_tag_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_fmt_q    <= out_fmt_d;
      out_ill_q    <= out_ill_d;
      out_tag_q    <= out_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
      skid_ill_q   <= skid_ill_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

  assign bus.in_ready    = !skid_valid_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = out_imm_q;
  assign bus.out_fmt     = out_fmt_q;
  assign bus.out_illegal = out_ill_q;
  assign bus.out_tag     = out_tag_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: XLEN=32 and XLEN=64
// instances driven by one shared input stream.
module tb_imm_decode_stage;
  import imm_pkg::*;

  typedef struct {
    logic [63:0] imm;
    logic [3:0]  fmt;
    logic        ill;
    logic [7:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [7:0]  in_tag = '0;
  logic        out_ready = 1'b0;
  int checks = 0;
  int errors = 0;

  imm_if #(.XLEN(32), .TAG_W(8)) b32 ();
  imm_if #(.XLEN(64), .TAG_W(8)) b64 ();

  assign b32.in_valid  = in_valid;
  assign b32.in_instr  = in_instr;
  assign b32.in_tag    = in_tag;
  assign b32.out_ready = out_ready;
  assign b64.in_valid  = in_valid;
  assign b64.in_instr  = in_instr;
  assign b64.in_tag    = in_tag;
  assign b64.out_ready = out_ready;

  imm_decode_stage #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32)
  );
  imm_decode_stage #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64)
  );

  always #5 clk = ~clk;

  // Reference decode from the ISA immediate layouts.
  function automatic exp_t ref_dec(input logic [31:0] i,
                                   input int xl,
                                   input logic [7:0] tag);
    exp_t r;
    longint s;
    int top;
    logic [2:0] f3;
    r.imm = '0; r.fmt = 4'd0; r.ill = 1'b0; r.tag = tag;
    s = longint'($signed(i));
    f3 = i[14:12];
    case (i[6:0])
      7'h13:
        if (f3 == 3'd1 || f3 == 3'd5) begin
          top = (xl == 64) ? int'(i[31:26]) * 2 : int'(i[31:25]);
          if (top == 0 || (top == 32 && f3 == 3'd5)) begin
            r.fmt = 4'd7;
            r.imm = (xl == 64) ? 64'(i[25:20]) : 64'(i[24:20]);
          end else r.ill = 1'b1;
        end else begin r.fmt = 4'd1; r.imm = s >>> 20; end
      7'h03, 7'h67, 7'h0F: begin r.fmt = 4'd1; r.imm = s >>> 20; end
      7'h73:
        if (f3 == 3'd0) begin r.fmt = 4'd1; r.imm = s >>> 20; end
        else begin r.fmt = 4'd8; r.imm = 64'(i[19:15]); end
      7'h23: begin
        r.fmt = 4'd2;
        r.imm = ((s >>> 25) <<< 5) | longint'(i[11:7]);
      end
      7'h63: begin
        r.fmt = 4'd3;
        r.imm = ((s >>> 31) <<< 12) | (longint'(i[7]) <<< 11) |
                (longint'(i[30:25]) <<< 5) | (longint'(i[11:8]) <<< 1);
      end
      7'h37, 7'h17: begin r.fmt = 4'd4; r.imm = (s >>> 12) <<< 12; end
      7'h6F: begin
        r.fmt = 4'd5;
        r.imm = ((s >>> 31) <<< 20) | (longint'(i[19:12]) <<< 12) |
                (longint'(i[20]) <<< 11) | (longint'(i[30:21]) <<< 1);
      end
      7'h33: r.fmt = 4'd6;
      7'h1B:
        if (xl == 64) begin r.fmt = 4'd1; r.imm = s >>> 20; end
        else r.ill = 1'b1;
      7'h3B:
        if (xl == 64) r.fmt = 4'd6;
        else r.ill = 1'b1;
      default: r.ill = 1'b1;
    endcase
    if (xl == 32) r.imm[63:32] = '0;
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 16);
    case (k)
      0: w[6:0] = 7'h03;  1: w[6:0] = 7'h0F;
      2: w[6:0] = 7'h13;  3: w[6:0] = 7'h17;
      4: w[6:0] = 7'h1B;  5: w[6:0] = 7'h23;
      6: w[6:0] = 7'h33;  7: w[6:0] = 7'h37;
      8: w[6:0] = 7'h3B;  9: w[6:0] = 7'h63;
      10: w[6:0] = 7'h67; 11: w[6:0] = 7'h6F;
      12: w[6:0] = 7'h73;
      13, 14: begin
        w[6:0] = 7'h13;
        w[13:12] = 2'b01;
        w[31:26] = {1'b0, w[30], 4'b0};
      end
      default: ;
    endcase
    return w;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({b32.out_valid, b32.out_imm, b32.out_fmt, b32.out_illegal,
         b32.out_tag, b32.in_ready} !== {1'b0, 32'd0, 4'd0, 1'b0, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset32 got v=%b imm=%h fmt=%0d",
               b32.out_valid, b32.out_imm, b32.out_fmt);
    end
    checks++;
    if ({b64.out_valid, b64.out_imm, b64.out_fmt, b64.out_illegal,
         b64.out_tag} !== {1'b0, 64'd0, 4'd0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset64 got v=%b imm=%h fmt=%0d",
               b64.out_valid, b64.out_imm, b64.out_fmt);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_encodings;
    logic [31:0] ins [12];
    logic [63:0] e32 [12];
    logic [3:0]  f32 [12];
    logic        i32 [12];
    logic [63:0] e64 [12];
    logic [3:0]  f64 [12];
    logic        i64 [12];
    ins[0]  = 32'hFFF00093; e32[0]  = 64'hFFFFFFFF;  f32[0]  = 4'd1; i32[0]  = 0;
    e64[0]  = 64'hFFFFFFFFFFFFFFFF; f64[0] = 4'd1; i64[0] = 0;
    ins[1]  = 32'h0020A423; e32[1]  = 64'd8;  f32[1]  = 4'd2; i32[1]  = 0;
    e64[1]  = 64'd8; f64[1] = 4'd2; i64[1] = 0;
    ins[2]  = 32'hFE000EE3; e32[2]  = 64'hFFFFFFFC;  f32[2]  = 4'd3; i32[2]  = 0;
    e64[2]  = 64'hFFFFFFFFFFFFFFFC; f64[2] = 4'd3; i64[2] = 0;
    ins[3]  = 32'h123452B7; e32[3]  = 64'h12345000;  f32[3]  = 4'd4; i32[3]  = 0;
    e64[3]  = 64'h12345000; f64[3] = 4'd4; i64[3] = 0;
    ins[4]  = 32'h008000EF; e32[4]  = 64'd8;  f32[4]  = 4'd5; i32[4]  = 0;
    e64[4]  = 64'd8; f64[4] = 4'd5; i64[4] = 0;
    ins[5]  = 32'h00000000; e32[5]  = 64'd0;  f32[5]  = 4'd0; i32[5]  = 1;
    e64[5]  = 64'd0; f64[5] = 4'd0; i64[5] = 1;
    ins[6]  = 32'h02009093; e32[6]  = 64'd0;  f32[6]  = 4'd0; i32[6]  = 1;
    e64[6]  = 64'd32; f64[6] = 4'd7; i64[6] = 0;
    ins[7]  = 32'h800002B7; e32[7]  = 64'h80000000;  f32[7]  = 4'd4; i32[7]  = 0;
    e64[7]  = 64'hFFFFFFFF80000000; f64[7] = 4'd4; i64[7] = 0;
    ins[8]  = 32'hFFF0009B; e32[8]  = 64'd0;  f32[8]  = 4'd0; i32[8]  = 1;
    e64[8]  = 64'hFFFFFFFFFFFFFFFF; f64[8] = 4'd1; i64[8] = 0;
    ins[9]  = 32'h002081B3; e32[9]  = 64'd0;  f32[9]  = 4'd6; i32[9]  = 0;
    e64[9]  = 64'd0; f64[9] = 4'd6; i64[9] = 0;
    ins[10] = 32'h300FD073; e32[10] = 64'd31; f32[10] = 4'd8; i32[10] = 0;
    e64[10] = 64'd31; f64[10] = 4'd8; i64[10] = 0;
    ins[11] = 32'h4030D093; e32[11] = 64'd3;  f32[11] = 4'd7; i32[11] = 0;
    e64[11] = 64'd3; f64[11] = 4'd7; i64[11] = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      in_valid = 1'b1;
      in_instr = ins[k];
      in_tag = 8'(k + 8'h40);
      @(posedge clk); #1;
      checks++;
      if ({b32.out_valid, b32.out_imm, b32.out_fmt, b32.out_illegal, b32.out_tag}
          !== {1'b1, e32[k][31:0], f32[k], i32[k], 8'(k + 8'h40)}) begin
        errors++;
        $display("FAIL enc32[%0d] got imm=%h fmt=%0d ill=%b want imm=%h fmt=%0d ill=%b",
                 k, b32.out_imm, b32.out_fmt, b32.out_illegal,
                 e32[k][31:0], f32[k], i32[k]);
      end
      checks++;
      if ({b64.out_valid, b64.out_imm, b64.out_fmt, b64.out_illegal, b64.out_tag}
          !== {1'b1, e64[k], f64[k], i64[k], 8'(k + 8'h40)}) begin
        errors++;
        $display("FAIL enc64[%0d] got imm=%h fmt=%0d ill=%b want imm=%h fmt=%0d ill=%b",
                 k, b64.out_imm, b64.out_fmt, b64.out_illegal,
                 e64[k], f64[k], i64[k]);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    logic [31:0] ins [4];
    logic [5:0]  exp_tag [8];
    logic [7:0]  want [8];
    logic [7:0]  cur;
    logic [31:0] hold;
    exp_t e;
    ins[0] = 32'hFFF00093; ins[1] = 32'h0020A423;
    ins[2] = 32'hFE000EE3; ins[3] = 32'h123452B7;
    // step: expected out tag (0 = no output) and in_ready
    want[0] = 8'h00; want[1] = 8'hA0; want[2] = 8'hA0;
    want[3] = 8'hA0; want[4] = 8'hA1; want[5] = 8'hA2;
    want[6] = 8'hA3; want[7] = 8'h00;
    exp_tag[0] = 6'd1; exp_tag[1] = 6'd1; exp_tag[2] = 6'd0;
    exp_tag[3] = 6'd0; exp_tag[4] = 6'd1; exp_tag[5] = 6'd1;
    exp_tag[6] = 6'd1; exp_tag[7] = 6'd1;
    hold = '0;
    for (int s = 0; s < 8; s++) begin
      checks++;
      if (b32.in_ready !== exp_tag[s][0]) begin
        errors++;
        $display("FAIL bp_in_ready step %0d got %b want %b",
                 s, b32.in_ready, exp_tag[s][0]);
      end
      cur = want[s];
      checks++;
      if (cur == 8'h00) begin
        if (b32.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL bp_idle step %0d got valid=%b want 0", s, b32.out_valid);
        end
      end else begin
        e = ref_dec(ins[cur[1:0]], 32, cur);
        if ({b32.out_valid, b32.out_imm, b32.out_fmt, b32.out_illegal, b32.out_tag,
             b64.out_tag} !== {1'b1, e.imm[31:0], e.fmt, e.ill, cur, cur}) begin
          errors++;
          $display("FAIL bp_out step %0d got tag=%h imm=%h want tag=%h imm=%h",
                   s, b32.out_tag, b32.out_imm, cur, e.imm[31:0]);
        end
      end
      if (s == 3) begin
        checks++;
        if (b32.out_imm !== hold) begin
          errors++;
          $display("FAIL bp_stable got imm=%h want %h", b32.out_imm, hold);
        end
      end
      if (s == 1) hold = b32.out_imm;
      case (s)
        0: begin out_ready = 1'b0; in_valid = 1'b1; in_instr = ins[0]; in_tag = 8'hA0; end
        1: begin in_instr = ins[1]; in_tag = 8'hA1; end
        2: begin in_instr = ins[2]; in_tag = 8'hA2; end
        3: out_ready = 1'b1;
        5: begin in_instr = ins[3]; in_tag = 8'hA3; end
        6: in_valid = 1'b0;
        default: ;
      endcase
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'h008000EF; in_tag = 8'hB0;
    @(posedge clk); #1;
    in_tag = 8'hB1;
    @(posedge clk); #1;
    checks++;
    if ({b32.out_valid, b32.in_ready} !== 2'b10) begin
      errors++;
      $display("FAIL flush_full got valid=%b in_ready=%b want 1 0",
               b32.out_valid, b32.in_ready);
    end
    flush = 1'b1;
    in_tag = 8'hB2;
    @(posedge clk); #1;
    checks++;
    if ({b32.out_valid, b32.in_ready, b64.out_valid, b64.in_ready} !== 4'b0101) begin
      errors++;
      $display("FAIL flush got v32=%b r32=%b v64=%b r64=%b want 0 1 0 1",
               b32.out_valid, b32.in_ready, b64.out_valid, b64.in_ready);
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (b32.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop got valid=%b want 0", b32.out_valid);
    end
  endtask

  task automatic test_random;
    exp_t q32[$];
    exp_t q64[$];
    exp_t e;
    logic stall;
    logic [44:0] h32;
    logic [76:0] h64;
    stall = 1'b0;
    h32 = '0;
    h64 = '0;
    for (int c = 0; c < 800; c++) begin
      if (stall) begin
        checks++;
        if ({b32.out_imm, b32.out_fmt, b32.out_illegal, b32.out_tag} !== h32 ||
            {b64.out_imm, b64.out_fmt, b64.out_illegal, b64.out_tag} !== h64) begin
          errors++;
          $display("FAIL rnd_stable cycle %0d got %h want %h", c,
                   {b32.out_imm, b32.out_fmt, b32.out_illegal, b32.out_tag}, h32);
        end
      end
      if (c < 790) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_instr = rand_instr();
        in_tag = 8'($urandom);
        out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        in_valid = 1'b0;
        out_ready = 1'b1;
      end
      if (b32.out_valid && out_ready) begin
        checks++;
        if (q32.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra32 cycle %0d got tag=%h want none", c, b32.out_tag);
        end else begin
          e = q32.pop_front();
          if ({b32.out_imm, b32.out_fmt, b32.out_illegal, b32.out_tag}
              !== {e.imm[31:0], e.fmt, e.ill, e.tag}) begin
            errors++;
            $display("FAIL rnd32 cycle %0d got imm=%h fmt=%0d ill=%b tag=%h want imm=%h fmt=%0d ill=%b tag=%h",
                     c, b32.out_imm, b32.out_fmt, b32.out_illegal, b32.out_tag,
                     e.imm[31:0], e.fmt, e.ill, e.tag);
          end
        end
      end
      if (b64.out_valid && out_ready) begin
        checks++;
        if (q64.size() == 0) begin
          errors++;
          $display("FAIL rnd_extra64 cycle %0d got tag=%h want none", c, b64.out_tag);
        end else begin
          e = q64.pop_front();
          if ({b64.out_imm, b64.out_fmt, b64.out_illegal, b64.out_tag}
              !== {e.imm, e.fmt, e.ill, e.tag}) begin
            errors++;
            $display("FAIL rnd64 cycle %0d got imm=%h fmt=%0d ill=%b tag=%h want imm=%h fmt=%0d ill=%b tag=%h",
                     c, b64.out_imm, b64.out_fmt, b64.out_illegal, b64.out_tag,
                     e.imm, e.fmt, e.ill, e.tag);
          end
        end
      end
      if (in_valid && b32.in_ready) q32.push_back(ref_dec(in_instr, 32, in_tag));
      if (in_valid && b64.in_ready) q64.push_back(ref_dec(in_instr, 64, in_tag));
      stall = b32.out_valid && !out_ready;
      h32 = {b32.out_imm, b32.out_fmt, b32.out_illegal, b32.out_tag};
      h64 = {b64.out_imm, b64.out_fmt, b64.out_illegal, b64.out_tag};
      @(posedge clk); #1;
    end
    checks++;
    if (q32.size() != 0 || q64.size() != 0 || b32.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rnd_drain got pending32=%0d pending64=%0d want 0 0",
               q32.size(), q64.size());
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'hFFF00093; in_tag = 8'hC0;
    @(posedge clk); #1;
    in_tag = 8'hC1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({b32.out_valid, b32.out_imm, b32.out_fmt, b32.out_illegal, b32.out_tag,
         b32.in_ready, b64.out_valid, b64.out_imm}
        !== {1'b0, 32'd0, 4'd0, 1'b0, 8'd0, 1'b1, 1'b0, 64'd0}) begin
      errors++;
      $display("FAIL reset_mid got v=%b imm=%h tag=%h rdy=%b want 0 0 0 1",
               b32.out_valid, b32.out_imm, b32.out_tag, b32.in_ready);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({b32.out_valid, b64.out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_after got v32=%b v64=%b want 0 0",
               b32.out_valid, b64.out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_encodings();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
